// File: rtl/irq_pkg.sv
// Shared sizes and types for the interrupt pending controller.
package irq_pkg;

   localparam int NUM_SRC = 4;
   localparam int ID_W    = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   typedef logic [NUM_SRC-1:0] src_vec_t;

endpackage

// File: rtl/irq_pending_ctrl_prio_enc4.sv
// Combinational 4-to-2 priority encoder; the highest set bit wins.
module prio_enc4
   import irq_pkg::*;
(
   input  src_vec_t          cand,
   output logic [ID_W-1:0]   id,
   output logic              any
);

   // Highest index first; id is 0 when nothing is set, qualified by any.
   always_comb begin
      id  = '0;
      any = |cand;
      if (cand[3])      id = 2'd3;
      else if (cand[2]) id = 2'd2;
      else if (cand[1]) id = 2'd1;
      else              id = 2'd0;
   end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky request capture, masking and one-at-a-time grant presentation
// over a valid/ack handshake.
module irq_pending_ctrl #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  req_in,
   input  logic [NUM_SRC-1:0]  mask_in,
   output logic                irq_valid,
   output logic [ID_W-1:0]     irq_id,
   input  logic                irq_ack,
   output logic [NUM_SRC-1:0]  pending,
   output logic [NUM_SRC-1:0]  overrun,
   input  logic                overrun_clr
);

   import irq_pkg::*;

   src_vec_t          req_q;
   src_vec_t          rise;
   src_vec_t          clr;
   src_vec_t          cand;
   logic [ID_W-1:0]   enc_id;
   logic              enc_any;
   state_t            state;
   state_t            state_next;
   logic [ID_W-1:0]   id_next;

   assign rise      = req_in & ~req_q;
   assign cand      = pending & ~mask_in;
   assign irq_valid = (state == PRESENT);

   // Retire the presented source only on an accepted handshake.
   always_comb begin
      clr = '0;
      if ((state == PRESENT) && irq_ack) clr[irq_id] = 1'b1;
   end

   prio_enc4 u_enc (
      .cand (cand),
      .id   (enc_id),
      .any  (enc_any)
   );

   // Edge detect history; a line held high through reset yields one rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) req_q <= '0;
      else     req_q <= req_in;
   end

   // Sticky pending flags; a new rise beats a same-cycle retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr) | rise;
   end

   // Overrun flags a repeat edge on a still-pending source; set beats clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= '0;
      else     overrun <= (overrun_clr ? '0 : overrun) | (rise & pending & ~clr);
   end

   // Grant state and latched index; the index is frozen while presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         irq_id <= '0;
      end else begin
         state  <= state_next;
         irq_id <= id_next;
      end
   end

   // Next-state: pick a source from IDLE, wait for ack in PRESENT.
   always_comb begin
      state_next = state;
      id_next    = irq_id;
      case (state)
         IDLE: begin
            if (enc_any) begin
               state_next = PRESENT;
               id_next    = enc_id;
            end
         end
         PRESENT: begin
            if (irq_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
